// File: rtl/collision_manager_if.sv
// collision_manager_if
//   Bundles the per-pixel inputs and the collision/frame outputs of
//   collision_manager. clk and resetN stay outside as plain ports.
//
//   Parameters
//     NUM_OBJ : number of object channels
//     CNT_W   : width of each per-object hit counter
//
//   Signals
//     startOfFrame    : one-cycle pulse on the first pixel of a frame
//     enable          : detection enable
//     clear_counts    : one-cycle request to zero all hit counters
//     drawing_request : per-object draw request for the current pixel
//     collision_now   : combinational per-object collision on this pixel
//     hit_pulse       : registered, at most once per object per frame
//     any_hit_pulse   : registered OR of hit_pulse
//     frame_hits      : objects hit during the last completed frame
//     frame_valid     : one-cycle pulse when frame_hits updates
//     hit_count       : flattened counters, object k at [k*CNT_W +: CNT_W]
//
//   Modports: master drives the inputs, slave is the collision manager.

interface collision_manager_if #(
   parameter int unsigned NUM_OBJ = 8,
   parameter int unsigned CNT_W   = 8
);

   logic                       startOfFrame;
   logic                       enable;
   logic                       clear_counts;
   logic [NUM_OBJ-1:0]         drawing_request;
   logic [NUM_OBJ-1:0]         collision_now;
   logic [NUM_OBJ-1:0]         hit_pulse;
   logic                       any_hit_pulse;
   logic [NUM_OBJ-1:0]         frame_hits;
   logic                       frame_valid;
   logic [NUM_OBJ*CNT_W-1:0]   hit_count;

   modport master (
      output startOfFrame,
      output enable,
      output clear_counts,
      output drawing_request,
      input  collision_now,
      input  hit_pulse,
      input  any_hit_pulse,
      input  frame_hits,
      input  frame_valid,
      input  hit_count
   );

   modport slave (
      input  startOfFrame,
      input  enable,
      input  clear_counts,
      input  drawing_request,
      output collision_now,
      output hit_pulse,
      output any_hit_pulse,
      output frame_hits,
      output frame_valid,
      output hit_count
   );

endinterface

// File: rtl/collision_manager.sv
// collision_manager
//   Pixel-rate collision detector for NUM_OBJ drawable objects. Two objects
//   collide on a pixel when both request drawing and their pair is enabled
//   in PAIR_MASK. Per-frame hit flags produce one hit_pulse per object per
//   frame; at each frame close the flags are published on frame_hits and
//   per-object saturating counters count frames containing a hit.
//
//   Parameters
//     NUM_OBJ   : object channels, legal range 2..16
//     PAIR_MASK : bit [i*NUM_OBJ+j], i<j, enables pair (i,j); bits i>=j unused
//     CNT_W     : width of each hit counter
//
//   Ports
//     clk    : system clock, rising edge
//     resetN : synchronous active-low reset
//     bus    : collision_manager_if slave (inputs, collision and frame outputs)

module collision_manager #(
   parameter int unsigned                NUM_OBJ   = 8,
   parameter logic [NUM_OBJ*NUM_OBJ-1:0] PAIR_MASK = '1,
   parameter int unsigned                CNT_W     = 8
) (
   input logic                clk,
   input logic                resetN,
   collision_manager_if.slave bus
);

   typedef enum logic [0:0] {
      StWaitSof = 1'b0,
      StActive  = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [NUM_OBJ-1:0] flag_q, flag_d;
   logic [NUM_OBJ-1:0] hit_pulse_q, hit_pulse_d;
   logic               any_hit_q, any_hit_d;
   logic [NUM_OBJ-1:0] frame_hits_q, frame_hits_d;
   logic               frame_valid_q, frame_valid_d;
   logic [CNT_W-1:0]   cnt_q [NUM_OBJ];
   logic [CNT_W-1:0]   cnt_d [NUM_OBJ];

   logic [NUM_OBJ-1:0] coll;
   logic               enter_frame;
   logic               run_frame;
   logic               close_frame;

   // Only the upper triangle of PAIR_MASK is meaningful; fold (i,j) onto it.
   function automatic logic pair_enabled(int unsigned a, int unsigned b);
      int unsigned lo;
      int unsigned hi;
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      return PAIR_MASK[lo*NUM_OBJ+hi];
   endfunction

   // Pure combinational detection, independent of state and enable.
   always_comb begin
      coll = '0;
      for (int unsigned i = 0; i < NUM_OBJ; i++) begin
         for (int unsigned j = 0; j < NUM_OBJ; j++) begin
            if (i != j && bus.drawing_request[i] && bus.drawing_request[j]
                && pair_enabled(i, j)) begin
               coll[i] = 1'b1;
            end
         end
      end
   end

   assign enter_frame = (state_q == StWaitSof) && bus.startOfFrame && bus.enable;
   assign run_frame   = (state_q == StActive) && bus.enable;
   assign close_frame = run_frame && bus.startOfFrame;

   always_comb begin
      state_d       = state_q;
      flag_d        = flag_q;
      hit_pulse_d   = '0;
      frame_hits_d  = frame_hits_q;
      frame_valid_d = 1'b0;
      for (int unsigned k = 0; k < NUM_OBJ; k++) begin
         cnt_d[k] = cnt_q[k];
      end

      unique case (state_q)
         StWaitSof: begin
            if (enter_frame) begin
               state_d = StActive;
               // Stale flags from a discarded partial frame are dropped here;
               // the startOfFrame pixel itself counts toward the new frame.
               flag_d      = coll;
               hit_pulse_d = coll;
            end
         end
         StActive: begin
            if (!bus.enable) begin
               state_d = StWaitSof;
            end else if (close_frame) begin
               frame_hits_d  = flag_q;
               frame_valid_d = 1'b1;
               flag_d        = coll;
               hit_pulse_d   = coll;
               for (int unsigned k = 0; k < NUM_OBJ; k++) begin
                  if (flag_q[k] && cnt_q[k] != {CNT_W{1'b1}}) begin
                     cnt_d[k] = cnt_q[k] + CNT_W'(1);
                  end
               end
            end else begin
               flag_d      = flag_q | coll;
               hit_pulse_d = coll & ~flag_q;
            end
         end
         default: state_d = StWaitSof;
      endcase

      // Clearing overrides a simultaneous frame-close increment.
      if (bus.clear_counts) begin
         for (int unsigned k = 0; k < NUM_OBJ; k++) begin
            cnt_d[k] = '0;
         end
      end

      any_hit_d = |hit_pulse_d;
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q       <= StWaitSof;
         flag_q        <= '0;
         hit_pulse_q   <= '0;
         any_hit_q     <= 1'b0;
         frame_hits_q  <= '0;
         frame_valid_q <= 1'b0;
         for (int unsigned k = 0; k < NUM_OBJ; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         state_q       <= state_d;
         flag_q        <= flag_d;
         hit_pulse_q   <= hit_pulse_d;
         any_hit_q     <= any_hit_d;
         frame_hits_q  <= frame_hits_d;
         frame_valid_q <= frame_valid_d;
         for (int unsigned k = 0; k < NUM_OBJ; k++) begin
            cnt_q[k] <= cnt_d[k];
         end
      end
   end

   always_comb begin
      bus.hit_count = '0;
      for (int unsigned k = 0; k < NUM_OBJ; k++) begin
         bus.hit_count[k*CNT_W +: CNT_W] = cnt_q[k];
      end
   end

   assign bus.collision_now = coll;
   assign bus.hit_pulse     = hit_pulse_q;
   assign bus.any_hit_pulse = any_hit_q;
   assign bus.frame_hits    = frame_hits_q;
   assign bus.frame_valid   = frame_valid_q;

endmodule
